// File: rtl/dq2.sv
// Two-lane streaming JPEG dequantizer: packed signed 16-bit coefficient pairs are
// scaled by a loadable 64-entry Q table and saturated back to 16 bits.

module dq2_lane #(
    parameter int QW = 16
) (
    input  logic signed [15:0]   coef,
    input  logic        [QW-1:0] q,
    output logic        [15:0]   res
);
    localparam int PW = QW + 17;
    localparam logic signed [PW-1:0] MAXV = PW'(32767);
    localparam logic signed [PW-1:0] MINV = -PW'(32768);

    logic signed [PW-1:0] c_ext, q_ext, p;

    // q is unsigned; zero-extend so the product stays signed and exact
    assign c_ext = PW'(coef);
    assign q_ext = PW'({1'b0, q});
    assign p     = c_ext * q_ext;

    always_comb begin
        res = p[15:0];
        if (p > MAXV)      res = 16'h7fff;
        else if (p < MINV) res = 16'h8000;
    end
endmodule

module dq2 #(
    parameter int QW    = 16,
    parameter int WORDS = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          qt_we_i,
    input  logic [5:0]    qt_addr_i,
    input  logic [QW-1:0] qt_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [31:0]   x_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   x_o,
    output logic          out_last_o
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 16;
    localparam int STAGES    = 2;
    localparam int CW        = $clog2(WORDS);

    logic [63:0][QW-1:0]                qt;
    logic [CW-1:0]                      cnt;
    logic [STAGES:1]                    vld_pipe;
    logic                               en, last1;
    logic [NUM_LANES-1:0][VEC_W-1:0]    x1, res;
    logic [NUM_LANES-1:0][QW-1:0]       q_rd, q1;

    assign en          = ~out_valid_o | out_ready_i;
    assign in_ready_o  = en & ~clr_i;
    assign out_valid_o = vld_pipe[STAGES];

    // Lane 1 carries the even coefficient (upper half), lane 0 the odd one
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign q_rd[i] = qt[6'(2 * int'(cnt) + NUM_LANES - 1 - i)];
        dq2_lane #(.QW(QW)) u_lane (
            .coef (x1[i]),
            .q    (q1[i]),
            .res  (res[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < 64; j++) qt[j] <= QW'(1);
        end else if (qt_we_i) begin
            qt[qt_addr_i] <= qt_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe   <= '0;
            cnt        <= '0;
            x1         <= '0;
            q1         <= '0;
            last1      <= 1'b0;
            x_o        <= '0;
            out_last_o <= 1'b0;
        end else if (clr_i) begin
            vld_pipe   <= '0;
            cnt        <= '0;
            out_last_o <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid_i};
            if (in_valid_i) begin
                x1    <= x_i;
                q1    <= q_rd;
                last1 <= (cnt == CW'(WORDS - 1));
                cnt   <= (cnt == CW'(WORDS - 1)) ? '0 : cnt + CW'(1);
            end
            // x_o only moves on a real word so a bubble leaves the last result visible
            if (vld_pipe[1]) x_o <= res;
            out_last_o <= vld_pipe[1] & last1;
        end
    end
endmodule

// File: doc/dq2.md
Name: dq2

Overview:
- Streaming JPEG dequantizer, the inverse of the two-lane quantizer stage.
- Takes packed pairs of signed 16-bit quantized coefficients, 32 words per 8x8 block, in zigzag/table order.
- Multiplies each coefficient by its quantization table entry, saturates, and emits the packed result toward the IDCT.
- Holds its own loadable 64-entry Q table and tracks block position internally.

Parameters:
- QW, 16, width of a Q-table entry (unsigned).
- WORDS, 32, packed words per block (64 coefficients / 2).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous restart: word counter to 0, pipeline valids cleared
- qt_we_i  in  1  Q-table write strobe
- qt_addr_i  in  6  Q-table entry index 0..63
- qt_data_i  in  QW  Q-table entry value
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when valid & ready
- x_i  in  32  [31:16] coefficient 2k, [15:0] coefficient 2k+1, signed
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream accepts
- x_o  out  32  [31:16] dequantized 2k, [15:0] dequantized 2k+1
- out_last_o  out  1  high with the output word of index 31 (block end)

Behaviour:
- Reset is asynchronous and active-low, on rst_ni, with a single clock clk_i.
- Reset values:
  - out_valid_o=0, x_o=0, out_last_o=0.
  - Word counter=0, both stage valids=0.
  - Q table = all 1 (identity dequantization).
- Q table: 64 x QW flop array, written synchronously on qt_we_i.
  - Read is combinational.
  - Same-cycle read of the entry being written returns the old value.
  - Writes are accepted in any cycle. Loading between blocks is a software rule, not enforced.
- Pipeline: two stages, with global advance en = ~out_valid_o | out_ready_i. in_ready_o = en.
  - Stage 1 (on in_valid_i & en):
    - Register x_i.
    - Register q_hi = Q[2*cnt] and q_lo = Q[2*cnt+1].
    - Register last = (cnt==WORDS-1).
    - v1 <= in_valid_i when en.
  - Stage 2 (on en):
    - p = signed(coef) * unsigned(q), 33-bit signed.
    - Saturate to [-32768, 32767].
    - Register into x_o and out_last_o; out_valid_o <= v1.
- Latency: 2 cycles from accept to out_valid_o with no backpressure. Throughput: 1 word/cycle.
- Backpressure: when out_valid_o & ~out_ready_i, both stages and the counter freeze, and x_o holds stable.
- Word counter:
  - Increments on each accepted input word.
  - Wraps 31 -> 0, with no gap between blocks.
  - out_last_o is asserted exactly on every 32nd output word.
- clr_i:
  - Takes priority over accept in the same cycle; the word presented that cycle is not accepted.
  - in_ready_o is forced 0 while clr_i=1.
  - Clears v1 and out_valid_o.
  - Leaves the Q table untouched.
- Q entry 0 yields 0 output for any input. The sign of zero is irrelevant.
- Reset mid-block: all in-flight words are discarded and the counter returns to 0.

Test Plan:
- Reset, no table load, stream 32 words x_i=0x0005_FFFD (+5, -3):
  - Required: 32 outputs 0x0005_FFFD, latency 2, out_last_o only on word 32.
- Load Q[0]=16, Q[1]=11, then word 0 x_i=0x0003_FFFE:
  - Required: x_o=0x0030_FFEA (+48, -22).
- Load Q[2]=Q[3]=0xFFFF, then send words 0..1 with word 1 x_i=0x7FFF_8000:
  - Required: saturation, output 0x7FFF_8000.
  - Repeat with 0x0001_FFFF: required output 0x7FFF_8000 (+65535 sat, -65535 sat).
- Stream 3 words, hold out_ready_i=0 for 5 cycles:
  - Required: in_ready_o=0 and x_o stable during the stall, no loss or duplication.
  - After release, outputs appear in order on consecutive cycles.
- Send 10 words, pulse clr_i, send a new block:
  - Required: in-flight outputs dropped.
  - New block word 0 uses Q[0..1], and out_last_o lands on its 32nd word.
- Assert rst_ni low mid-stream, asynchronously between clock edges:
  - Required: out_valid_o drops immediately, and Q reads back as all 1 on the next block.
